// File: rtl/timer_status_if.sv
// Register-write bus into the OPL3 timer/status block.
// The host side drives it as master; the timer block receives it as slave.
interface timer_status_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  reg_wr_valid;
    logic                  reg_wr_bank_num;
    logic [7:0]            reg_wr_address;
    logic [DATA_WIDTH-1:0] reg_wr_data;

    modport master (
        output reg_wr_valid,
        output reg_wr_bank_num,
        output reg_wr_address,
        output reg_wr_data
    );

    modport slave (
        input reg_wr_valid,
        input reg_wr_bank_num,
        input reg_wr_address,
        input reg_wr_data
    );
endinterface

// File: rtl/timer_status.sv
// OPL3 Timer 1/Timer 2 engine with the status byte and irq_n pin.
// Timers tick from prescaled sample_clk_en; flags are sticky until RST.
module timer_status #(
    parameter int T1_PRESCALE = 4,
    parameter int T2_DIVIDE   = 4,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 ic_n,
    input  logic                 sample_clk_en,
    timer_status_if.slave        wr,
    input  logic                 force_timer_overflow,
    output logic [7:0]           status,
    output logic                 irq_n
);
    localparam int P1W = (T1_PRESCALE > 1) ? $clog2(T1_PRESCALE) : 1;
    localparam int P2W = (T2_DIVIDE > 1) ? $clog2(T2_DIVIDE) : 1;
    localparam logic [P1W-1:0] P1_LAST = P1W'(T1_PRESCALE - 1);
    localparam logic [P2W-1:0] P2_LAST = P2W'(T2_DIVIDE - 1);

    typedef logic [DATA_WIDTH-1:0] word_t;
    localparam word_t CNT_MAX = '1;

    logic [P1W-1:0] p1_q, p1_d;
    logic [P2W-1:0] p2_q, p2_d;
    word_t          t1p_q, t1p_d, t2p_q, t2p_d;
    word_t          cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic           st1_q, st1_d, st2_q, st2_d;
    logic           mt1_q, mt1_d, mt2_q, mt2_d;
    logic           ft1_q, ft1_d, ft2_q, ft2_d;
    logic           irq_q, irq_d;
    logic           frc_q;

    logic wr_en, wr_t1p, wr_t2p, wr_ctl, wr_rst;
    logic tick1, tick2, frc_edge, ovf1, ovf2;
    logic unused_data;

    assign unused_data = ^wr.reg_wr_data;

    always_comb begin
        wr_en  = wr.reg_wr_valid && !wr.reg_wr_bank_num;
        wr_t1p = wr_en && (wr.reg_wr_address == 8'h02);
        wr_t2p = wr_en && (wr.reg_wr_address == 8'h03);
        wr_ctl = wr_en && (wr.reg_wr_address == 8'h04)
                 && !wr.reg_wr_data[7];
        wr_rst = wr_en && (wr.reg_wr_address == 8'h04)
                 && wr.reg_wr_data[7];

        tick1 = sample_clk_en && (p1_q == P1_LAST);
        tick2 = tick1 && (p2_q == P2_LAST);

        p1_d = p1_q;
        if (sample_clk_en)
            p1_d = tick1 ? '0 : p1_q + 1'b1;
        p2_d = p2_q;
        if (tick1)
            p2_d = tick2 ? '0 : p2_q + 1'b1;

        // A forced edge and a natural overflow merge into one event
        frc_edge = force_timer_overflow && !frc_q;
        ovf1 = st1_q && ((tick1 && cnt1_q == CNT_MAX) || frc_edge);
        ovf2 = st2_q && tick2 && (cnt2_q == CNT_MAX);

        t1p_d = wr_t1p ? wr.reg_wr_data : t1p_q;
        t2p_d = wr_t2p ? wr.reg_wr_data : t2p_q;
        st1_d = wr_ctl ? wr.reg_wr_data[0] : st1_q;
        st2_d = wr_ctl ? wr.reg_wr_data[1] : st2_q;
        mt1_d = wr_ctl ? wr.reg_wr_data[6] : mt1_q;
        mt2_d = wr_ctl ? wr.reg_wr_data[5] : mt2_q;

        cnt1_d = cnt1_q;
        if (st1_d && !st1_q)
            cnt1_d = t1p_q;
        else if (ovf1)
            cnt1_d = t1p_q;
        else if (st1_q && tick1)
            cnt1_d = cnt1_q + 1'b1;

        cnt2_d = cnt2_q;
        if (st2_d && !st2_q)
            cnt2_d = t2p_q;
        else if (ovf2)
            cnt2_d = t2p_q;
        else if (st2_q && tick2)
            cnt2_d = cnt2_q + 1'b1;

        // Clear first, then set: a coincident overflow survives RST
        ft1_d = (ft1_q && !wr_rst) || (ovf1 && !mt1_q);
        ft2_d = (ft2_q && !wr_rst) || (ovf2 && !mt2_q);
        irq_d = ft1_d || ft2_d;
    end

    always_ff @(posedge clk) begin
        if (!ic_n) begin
            p1_q   <= '0;
            p2_q   <= '0;
            t1p_q  <= '0;
            t2p_q  <= '0;
            cnt1_q <= '0;
            cnt2_q <= '0;
            st1_q  <= 1'b0;
            st2_q  <= 1'b0;
            mt1_q  <= 1'b0;
            mt2_q  <= 1'b0;
            ft1_q  <= 1'b0;
            ft2_q  <= 1'b0;
            irq_q  <= 1'b0;
            frc_q  <= 1'b0;
        end else begin
            p1_q   <= p1_d;
            p2_q   <= p2_d;
            t1p_q  <= t1p_d;
            t2p_q  <= t2p_d;
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
            st1_q  <= st1_d;
            st2_q  <= st2_d;
            mt1_q  <= mt1_d;
            mt2_q  <= mt2_d;
            ft1_q  <= ft1_d;
            ft2_q  <= ft2_d;
            irq_q  <= irq_d;
            frc_q  <= force_timer_overflow;
        end
    end

    assign status = {irq_q, ft1_q, ft2_q, 5'b0};
    assign irq_n  = !irq_q;
endmodule

// File: tb/tb_timer_status.sv
// Bench for timer_status: directed scenarios plus random traffic,
// compared every cycle against a pulse-counting reference model.
module tb_timer_status;
    localparam int PRE = 4;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       ic_n;
    logic       sample_clk_en;
    logic       force_timer_overflow;
    logic [7:0] status;
    logic       irq_n;

    timer_status_if #(.DATA_WIDTH(8)) bus ();

    timer_status #(
        .T1_PRESCALE(PRE),
        .T2_DIVIDE  (DIV),
        .DATA_WIDTH (8)
    ) dut (
        .clk                 (clk),
        .ic_n                (ic_n),
        .sample_clk_en       (sample_clk_en),
        .wr                  (bus.slave),
        .force_timer_overflow(force_timer_overflow),
        .status              (status),
        .irq_n               (irq_n)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: pulse totals and integer counters
    int m_pulses, m_ticks1;
    int m_t1p, m_t2p, m_cnt1, m_cnt2;
    bit m_st1, m_st2, m_mt1, m_mt2, m_ft1, m_ft2, m_fprev;
    bit frc_lvl;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_status();
        return {m_ft1 | m_ft2, m_ft1, m_ft2, 5'b0};
    endfunction

    task automatic step(input bit rn, input bit se, input bit wv,
                        input bit bk, input bit [7:0] ad,
                        input bit [7:0] dt, input bit fo);
        bit t1, t2, fe, ov1, ov2, wc, wrst, n1, n2;
        ic_n                 = rn;
        sample_clk_en        = se;
        bus.reg_wr_valid     = wv;
        bus.reg_wr_bank_num  = bk;
        bus.reg_wr_address   = ad;
        bus.reg_wr_data      = dt;
        force_timer_overflow = fo;
        if (!rn) begin
            m_pulses = 0; m_ticks1 = 0;
            m_t1p = 0; m_t2p = 0; m_cnt1 = 0; m_cnt2 = 0;
            m_st1 = 0; m_st2 = 0; m_mt1 = 0; m_mt2 = 0;
            m_ft1 = 0; m_ft2 = 0; m_fprev = 0;
        end else begin
            t1 = se && ((m_pulses + 1) % PRE == 0);
            t2 = t1 && ((m_ticks1 + 1) % DIV == 0);
            if (se) m_pulses++;
            if (t1) m_ticks1++;
            fe  = fo && !m_fprev;
            ov1 = m_st1 && ((t1 && m_cnt1 == 255) || fe);
            ov2 = m_st2 && t2 && m_cnt2 == 255;
            wc   = wv && !bk && ad == 8'h04 && !dt[7];
            wrst = wv && !bk && ad == 8'h04 && dt[7];
            n1 = wc ? dt[0] : m_st1;
            n2 = wc ? dt[1] : m_st2;
            if (n1 && !m_st1) m_cnt1 = m_t1p;
            else if (ov1) m_cnt1 = m_t1p;
            else if (m_st1 && t1) m_cnt1 = (m_cnt1 + 1) % 256;
            if (n2 && !m_st2) m_cnt2 = m_t2p;
            else if (ov2) m_cnt2 = m_t2p;
            else if (m_st2 && t2) m_cnt2 = (m_cnt2 + 1) % 256;
            if (wrst) begin m_ft1 = 0; m_ft2 = 0; end
            if (ov1 && !m_mt1) m_ft1 = 1;
            if (ov2 && !m_mt2) m_ft2 = 1;
            if (wc) begin m_mt1 = dt[6]; m_mt2 = dt[5]; end
            m_st1 = n1; m_st2 = n2;
            if (wv && !bk && ad == 8'h02) m_t1p = dt;
            if (wv && !bk && ad == 8'h03) m_t2p = dt;
            m_fprev = fo;
        end
        @(posedge clk);
        #1;
        chk("model_status", status, m_status());
        chk("model_irq_n", {7'b0, irq_n}, {7'b0, !(m_ft1 | m_ft2)});
    endtask

    task automatic reset();
        frc_lvl = 0;
        step(0, 0, 0, 0, 8'h00, 8'h00, 0);
    endtask

    task automatic wr(input bit [7:0] ad, input bit [7:0] dt);
        step(1, 0, 1, 0, ad, dt, frc_lvl);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++)
            step(1, 1, 0, 0, 8'h00, 8'h00, frc_lvl);
    endtask

    initial begin
        bit rn, se, wv, bk;
        bit [7:0] ad, dt;

        reset();
        chk("reset_status", status, 8'h00);
        chk("reset_irq_n", {7'b0, irq_n}, 8'h01);
        pulses(100);
        chk("idle_status", status, 8'h00);

        // Timer 1 from 0xFE: overflow on the 8th pulse, reload, again
        reset();
        wr(8'h02, 8'hFE);
        wr(8'h04, 8'h01);
        pulses(7);
        chk("t1_pre_ovf", status, 8'h00);
        pulses(1);
        chk("t1_ovf", status, 8'hC0);
        chk("t1_irq_n", {7'b0, irq_n}, 8'h00);
        wr(8'h04, 8'h80);
        chk("t1_rst", status, 8'h00);
        pulses(7);
        chk("t1_reload_pre", status, 8'h00);
        pulses(1);
        chk("t1_reload_ovf", status, 8'hC0);

        // Timer 2 from 0xFF: overflow every 16 pulses
        reset();
        wr(8'h03, 8'hFF);
        wr(8'h04, 8'h02);
        pulses(15);
        chk("t2_pre_ovf", status, 8'h00);
        pulses(1);
        chk("t2_ovf", status, 8'hA0);
        wr(8'h04, 8'h80);
        chk("t2_rst", status, 8'h00);
        pulses(15);
        chk("t2_again_pre", status, 8'h00);
        pulses(1);
        chk("t2_again", status, 8'hA0);

        // Read-trick detection sequence
        reset();
        wr(8'h04, 8'h60);
        wr(8'h04, 8'h80);
        wr(8'h02, 8'hFF);
        wr(8'h04, 8'h21);
        chk("det_before", status, 8'h00);
        frc_lvl = 1;
        wr(8'h00, 8'h00);
        chk("det_after", status, 8'hC0);
        wr(8'h04, 8'h80);
        wr(8'h00, 8'h00);
        chk("det_level_hold", status, 8'h00);

        reset();
        wr(8'h04, 8'h60);
        wr(8'h04, 8'h80);
        wr(8'h02, 8'hFF);
        wr(8'h04, 8'h61);
        frc_lvl = 1;
        wr(8'h00, 8'h00);
        chk("det_masked", status, 8'h00);

        // Force edge while stopped
        reset();
        wr(8'h02, 8'hFF);
        frc_lvl = 1;
        wr(8'h00, 8'h00);
        chk("force_stopped", status, 8'h00);

        // RST on the same cycle as a tick1 overflow
        reset();
        wr(8'h02, 8'hFF);
        wr(8'h04, 8'h01);
        pulses(3);
        step(1, 1, 1, 0, 8'h04, 8'h80, 0);
        chk("rst_vs_ovf", status, 8'hC0);

        // Reset mid-count, then full 256-tick period from preset 0
        pulses(5);
        reset();
        chk("midreset_status", status, 8'h00);
        chk("midreset_irq_n", {7'b0, irq_n}, 8'h01);
        wr(8'h04, 8'h01);
        pulses(1023);
        chk("t1p0_pre", status, 8'h00);
        pulses(1);
        chk("t1p0_ovf", status, 8'hC0);

        // Random traffic
        reset();
        for (int i = 0; i < 3000; i++) begin
            rn = ($urandom_range(0, 299) != 0);
            se = 1'($urandom_range(0, 1));
            wv = ($urandom_range(0, 3) == 0);
            bk = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: ad = 8'h02;
                1: ad = 8'h03;
                2: ad = 8'h04;
                default: ad = 8'($urandom);
            endcase
            dt = 8'($urandom);
            if ((ad == 8'h02 || ad == 8'h03) && $urandom_range(0, 3) != 0)
                dt = dt | 8'hF0;
            if ($urandom_range(0, 15) == 0)
                frc_lvl = !frc_lvl;
            if (!rn) frc_lvl = 0;
            step(rn, se, wv, bk, ad, dt, frc_lvl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
